rr_count_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-state strobe-counting engine (A→B→C→D→A, y high in D) among N requesters. It grants the engine to one requester at a time, steers that requester's strobe into the counter, and releases the grant on a completed count, a withdrawn request, or an inactivity timeout. It sits between the per-channel request logic and the shared counting resource.

---
 rtl/rr_count_arbiter.sv | 151 +++++++++++++++
 tb/tb_rr_count_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_count_arbiter.sv
// ---------------------------------------------------------------------------
// rr_count_arbiter
//
// Shares one 4-state strobe-counting engine (A->B->C->D->A, y high in D)
// among N requesters. A round-robin search picks the next owner, the owner's
// strobe drives the shared counter, and the grant is released on a
// completed count, a withdrawn request or an inactivity timeout.
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   req_i   : per-requester request level
//   x_i     : per-requester count strobe (only the owner's bit is used)
//   gnt_o   : registered one-hot grant, zero when there is no owner
//   busy_o  : high whenever gnt_o is non-zero
//   y_o     : high while the owner's count sits in state D
//   done_o  : one-cycle pulse on the owner's bit when its 4th strobe lands
//   tmo_o   : one-cycle pulse when a grant is aborted by inactivity
// ---------------------------------------------------------------------------
module rr_count_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] x_i,
    output logic [N-1:0] gnt_o,
    output logic         busy_o,
    output logic         y_o,
    output logic [N-1:0] done_o,
    output logic         tmo_o
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0]    CNT_A    = 2'd0;
    localparam logic [1:0]    CNT_D    = 2'd3;
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RELEASE = 2'd2
    } ctrl_e;

    ctrl_e         ctrl_q;
    logic [1:0]    count_q;
    logic [PW-1:0] last_q;   // last granted index; doubles as the current owner
    logic [IW-1:0] idle_q;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  done_q;
    logic          tmo_q;

    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic          own_req;
    logic          own_x;

    // Round-robin search starting at last_q+1. Walking the offsets from
    // farthest to nearest lets the nearest asserted request overwrite the
    // others, so the final value is the first hit in round-robin order.
    always_comb begin
        int cand;
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = 0;
        for (int i = N; i >= 1; i--) begin
            cand = (int'(last_q) + i) % N;
            if (req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign own_req = req_i[last_q];
    assign own_x   = x_i[last_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= IDLE;
            count_q <= CNT_A;
            last_q  <= PW'(N - 1);
            idle_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            done_q <= '0;
            tmo_q  <= 1'b0;
            unique case (ctrl_q)
                IDLE: begin
                    if (win_vld) begin
                        ctrl_q  <= COUNT;
                        last_q  <= win_idx;
                        gnt_q   <= ONE_HOT0 << win_idx;
                        count_q <= CNT_A;
                        idle_q  <= '0;
                    end
                end
                COUNT: begin
                    if (!own_req) begin
                        // Withdrawal beats a same-cycle strobe; silent abort.
                        ctrl_q  <= RELEASE;
                        gnt_q   <= '0;
                        count_q <= CNT_A;
                    end else if (own_x) begin
                        idle_q <= '0;
                        if (count_q == CNT_D) begin
                            ctrl_q  <= RELEASE;
                            done_q  <= gnt_q;
                            gnt_q   <= '0;
                            count_q <= CNT_A;
                        end else begin
                            count_q <= count_q + 2'd1;
                        end
                    end else if (idle_q == IDLE_MAX) begin
                        // This edge is the TIMEOUT-th consecutive quiet one.
                        ctrl_q  <= RELEASE;
                        tmo_q   <= 1'b1;
                        gnt_q   <= '0;
                        count_q <= CNT_A;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                RELEASE: begin
                    ctrl_q  <= IDLE;
                    gnt_q   <= '0;
                    count_q <= CNT_A;
                end
                default: begin
                    ctrl_q  <= IDLE;
                    gnt_q   <= '0;
                    count_q <= CNT_A;
                end
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = |gnt_q;
    assign y_o    = (ctrl_q == COUNT) && (count_q == CNT_D);
    assign done_o = done_q;
    assign tmo_o  = tmo_q;

endmodule

// File: tb/tb_rr_count_arbiter.sv
module tb_rr_count_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] x;
    logic [N-1:0] gnt;
    logic         busy;
    logic         y;
    logic [N-1:0] done;
    logic         tmo;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model
    int           m_owner;    // -1 when nobody holds the engine
    int           m_last;
    int           m_strobes;  // strobes counted in the current grant
    int           m_idle;     // consecutive quiet cycles in the current grant
    bit           m_cool;     // one cycle of enforced release after a grant
    logic [N-1:0] e_done;
    logic         e_tmo;

    rr_count_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req),
        .x_i    (x),
        .gnt_o  (gnt),
        .busy_o (busy),
        .y_o    (y),
        .done_o (done),
        .tmo_o  (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_strobes = 0;
        m_idle    = 0;
        m_cool    = 1'b0;
        e_done    = '0;
        e_tmo     = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] s);
        e_done = '0;
        e_tmo  = 1'b0;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (r[c]) begin
                    m_owner   = c;
                    m_last    = c;
                    m_strobes = 0;
                    m_idle    = 0;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
            m_cool  = 1'b1;
        end else if (s[m_owner]) begin
            m_idle = 0;
            m_strobes++;
            if (m_strobes == 4) begin
                e_done  = '0;
                e_done[m_owner] = 1'b1;
                m_owner = -1;
                m_cool  = 1'b1;
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                e_tmo   = 1'b1;
                m_owner = -1;
                m_cool  = 1'b1;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic check_all(input string tag);
        logic [N-1:0] g;
        g = exp_gnt();
        chk({tag, ".gnt"},  32'(gnt),  32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(g != '0));
        chk({tag, ".y"},    32'(y),    32'((m_owner >= 0) && (m_strobes == 3)));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".tmo"},  32'(tmo),  32'(e_tmo));
    endtask

    // Apply inputs, take one rising edge, advance the model, compare.
    task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] s);
        req = r;
        x   = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        x     = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 rst_n = 1'b1;

        // Single requester, four strobes
        step("single_gnt", 4'b0001, 4'b0000);
        chk("single_gnt_direct", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("single_x", 4'b0001, 4'b0001);
            if (i == 2) chk("single_y_after3", 32'(y), 32'h1);
        end
        chk("single_done", 32'(done), 32'h1);
        chk("single_gnt_off", 32'(gnt), 32'h0);
        step("single_idle", 4'b0000, 4'b0000);

        // Round-robin fairness; last owner was 0 so the rotation starts at 1
        for (int g = 0; g < 5; g++) begin
            logic [N-1:0] own;
            own = '0;
            own[(g + 1) % N] = 1'b1;
            step("rr_gnt", 4'b1111, 4'b0000);
            chk("rr_order", 32'(gnt), 32'(own));
            for (int i = 0; i < 4; i++) step("rr_x", 4'b1111, own);
            chk("rr_low1", 32'(gnt), 32'h0);
            step("rr_gap", 4'b1111, 4'b0000);
            chk("rr_low2", 32'(gnt), 32'h0);
        end
        // Owner 1 last; drain to a known point with owner 0 next
        step("drain", 4'b0001, 4'b0000);
        chk("iso_gnt", 32'(gnt), 32'h1);

        // Non-owner isolation: x[3:1] toggles, x[0] strobed twice
        step("iso_a", 4'b0001, 4'b1111);
        step("iso_b", 4'b0001, 4'b0001);
        step("iso_c", 4'b0001, 4'b1110);
        step("iso_d", 4'b0001, 4'b0000);
        chk("iso_y", 32'(y), 32'h0);

        // Withdrawal at count D together with a strobe
        step("wd_toD", 4'b0001, 4'b0001);
        chk("wd_yD", 32'(y), 32'h1);
        step("wd_abort", 4'b0000, 4'b0001);
        chk("wd_no_done", 32'(done), 32'h0);
        chk("wd_no_tmo", 32'(tmo), 32'h0);
        chk("wd_y_fall", 32'(y), 32'h0);
        step("wd_idle", 4'b0000, 4'b0000);

        // Timeout: owner 1 strobes once, then stays quiet
        step("to_gnt", 4'b0010, 4'b0000);
        chk("to_owner1", 32'(gnt), 32'h2);
        step("to_x", 4'b0110, 4'b0010);
        for (int j = 0; j < TIMEOUT; j++) begin
            step("to_quiet", 4'b0110, 4'b0000);
            if (j == TIMEOUT - 2) chk("to_not_yet", 32'(tmo), 32'h0);
        end
        chk("to_pulse", 32'(tmo), 32'h1);
        chk("to_gnt_off", 32'(gnt), 32'h0);
        step("to_rel", 4'b0110, 4'b0000);
        step("to_next", 4'b0110, 4'b0000);
        chk("to_next_owner2", 32'(gnt), 32'h4);

        // Mid-grant reset at count C
        step("mr_x1", 4'b0100, 4'b0100);
        step("mr_x2", 4'b0100, 4'b0100);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mr_async");
        req = 4'b1111;
        #1 rst_n = 1'b1;
        step("mr_first", 4'b1111, 4'b0000);
        chk("mr_owner0", 32'(gnt), 32'h1);

        // Randomized traffic against the model
        begin
            logic [N-1:0] r;
            int pct;
            r   = 4'b1111;
            pct = 50;
            for (int c = 0; c < 600; c++) begin
                logic [N-1:0] s;
                if (c % 40 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       pct = 0;
                        1:       pct = 30;
                        default: pct = 80;
                    endcase
                end
                for (int b = 0; b < N; b++) begin
                    if ($urandom_range(0, 99) < 6) r[b] = ~r[b];
                    s[b] = ($urandom_range(0, 99) < pct);
                end
                step("rand", r, s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
